// File: rtl/csi2rx_rgb888_b2p.sv
// csi2rx_rgb888_b2p: unpacks a stream of 32-bit CSI-2 payload dwords into
// 24-bit RGB888 pixels. Every three full dwords produce four pixels. The block
// handles the partial dword at the end of a line and flags line lengths that
// are not a whole number of pixels.
module csi2rx_rgb888_b2p (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rgb888_convrn_enable,
  input  logic [31:0] dw,
  input  logic        dw_vld,
  input  logic        dw_last,
  input  logic [2:0]  dw_nbytes,
  output logic        dw_rdy,
  output logic [23:0] pixel_data,
  output logic        pixel_vld,
  output logic        pixel_last,
  input  logic        pixel_rdy,
  output logic        len_err
);

  // The phase is the number of bytes currently held in the residue register.
  typedef enum logic [1:0] {
    PH_0 = 2'd0,
    PH_1 = 2'd1,
    PH_2 = 2'd2,
    PH_3 = 2'd3
  } phase_e;

  phase_e      phase_q, phase_d;
  logic [23:0] res_q, res_d;
  logic        last_pend_q, last_pend_d;
  logic [23:0] pixel_data_q, pixel_data_d;
  logic        pixel_vld_q, pixel_vld_d;
  logic        pixel_last_q, pixel_last_d;
  logic        len_err_q, len_err_d;

  logic        out_load;
  logic        accept;
  logic [2:0]  nbytes;
  logic [3:0]  total;
  logic [23:0] phase_pix;
  logic [23:0] phase_res;
  phase_e      phase_nxt;

  // Handshake: the output register may load when it is empty or being drained.
  // dw_rdy depends only on registered state, enable and pixel_rdy.
  always_comb begin
    out_load = !pixel_vld_q || pixel_rdy;
    dw_rdy   = rgb888_convrn_enable && out_load && (phase_q != PH_3);
    accept   = dw_vld && dw_rdy;
  end

  // Byte steering for an accepted dword in the current phase.
  always_comb begin
    phase_pix = dw[23:0];
    phase_res = {16'd0, dw[31:24]};
    phase_nxt = PH_1;
    unique case (phase_q)
      PH_1: begin
        phase_pix = {dw[15:0], res_q[7:0]};
        phase_res = {8'd0, dw[31:16]};
        phase_nxt = PH_2;
      end
      PH_2: begin
        phase_pix = {dw[7:0], res_q[15:0]};
        phase_res = dw[31:8];
        phase_nxt = PH_3;
      end
      default: ;
    endcase
    nbytes = dw_last ? dw_nbytes : 3'd4;
    total  = {2'd0, phase_q} + {1'b0, nbytes};
  end

  // Next-state logic for the residue, phase and output register.
  always_comb begin
    // NOTE: every signal assigned here gets a default first so no latch is inferred.
    phase_d      = phase_q;
    res_d        = res_q;
    last_pend_d  = last_pend_q;
    pixel_data_d = pixel_data_q;
    pixel_vld_d  = pixel_vld_q;
    pixel_last_d = pixel_last_q;
    len_err_d    = len_err_q;

    if (!rgb888_convrn_enable) begin
      phase_d      = PH_0;
      res_d        = '0;
      last_pend_d  = 1'b0;
      pixel_data_d = '0;
      pixel_vld_d  = 1'b0;
      pixel_last_d = 1'b0;
      len_err_d    = 1'b0;
    end else if (out_load) begin
      if (phase_q == PH_3) begin
        // Three residue bytes form a whole pixel without consuming a dword.
        pixel_data_d = res_q;
        pixel_vld_d  = 1'b1;
        pixel_last_d = last_pend_q;
        phase_d      = PH_0;
        res_d        = '0;
        last_pend_d  = 1'b0;
      end else if (accept) begin
        if (!dw_last) begin
          pixel_data_d = phase_pix;
          pixel_vld_d  = 1'b1;
          pixel_last_d = 1'b0;
          phase_d      = phase_nxt;
          res_d        = phase_res;
        end else if (nbytes == 3'd0 || nbytes > 3'd4) begin
          pixel_vld_d  = 1'b0;
          pixel_last_d = 1'b0;
          len_err_d    = 1'b1;
          phase_d      = PH_0;
          res_d        = '0;
          last_pend_d  = 1'b0;
        end else if (total == 4'd6) begin
          // Line ends exactly after the residue pixel that follows.
          pixel_data_d = phase_pix;
          pixel_vld_d  = 1'b1;
          pixel_last_d = 1'b0;
          phase_d      = PH_3;
          res_d        = phase_res;
          last_pend_d  = 1'b1;
        end else if (total >= 4'd3) begin
          // Exactly 3 bytes is a clean line end; 4 or 5 leaves stray bytes.
          pixel_data_d = phase_pix;
          pixel_vld_d  = 1'b1;
          pixel_last_d = 1'b1;
          phase_d      = PH_0;
          res_d        = '0;
          if (total != 4'd3) len_err_d = 1'b1;
        end else begin
          // Fewer than 3 bytes left in the line: no pixel can be formed.
          pixel_vld_d  = 1'b0;
          pixel_last_d = 1'b0;
          len_err_d    = 1'b1;
          phase_d      = PH_0;
          res_d        = '0;
        end
      end else begin
        pixel_vld_d  = 1'b0;
        pixel_last_d = 1'b0;
      end
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!rst_n) begin
      phase_q      <= PH_0;
      res_q        <= '0;
      last_pend_q  <= 1'b0;
      pixel_data_q <= '0;
      pixel_vld_q  <= 1'b0;
      pixel_last_q <= 1'b0;
      len_err_q    <= 1'b0;
    end else begin
      phase_q      <= phase_d;
      res_q        <= res_d;
      last_pend_q  <= last_pend_d;
      pixel_data_q <= pixel_data_d;
      pixel_vld_q  <= pixel_vld_d;
      pixel_last_q <= pixel_last_d;
      len_err_q    <= len_err_d;
    end
  end

  assign pixel_data = pixel_data_q;
  assign pixel_vld  = pixel_vld_q;
  assign pixel_last = pixel_last_q;
  assign len_err    = len_err_q;

endmodule

// File: tb/tb_csi2rx_rgb888_b2p.sv
// Bench for csi2rx_rgb888_b2p: a table of directed per-cycle vectors plus
// hand-written sequences for output stall and mid-line enable drop.
module tb_csi2rx_rgb888_b2p;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [31:0] dw;
  logic        dw_vld;
  logic        dw_last;
  logic [2:0]  dw_nbytes;
  logic        dw_rdy;
  logic [23:0] pixel_data;
  logic        pixel_vld;
  logic        pixel_last;
  logic        pixel_rdy;
  logic        len_err;

  int n_cmp = 0;
  int n_err = 0;

  csi2rx_rgb888_b2p dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .rgb888_convrn_enable (en),
    .dw                   (dw),
    .dw_vld               (dw_vld),
    .dw_last              (dw_last),
    .dw_nbytes            (dw_nbytes),
    .dw_rdy               (dw_rdy),
    .pixel_data           (pixel_data),
    .pixel_vld            (pixel_vld),
    .pixel_last           (pixel_last),
    .pixel_rdy            (pixel_rdy),
    .len_err              (len_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic [31:0] dw;
    logic        vld;
    logic        last;
    logic [2:0]  nb;
    logic        prdy;
    logic        exp_rdy;
    logic [23:0] exp_data;
    logic        exp_vld;
    logic        exp_last;
    logic        exp_err;
  } vec_t;

  localparam int NVEC = 15;
  vec_t vec [NVEC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, check dw_rdy before the edge and the
  // registered outputs just after it.
  task automatic step(input vec_t v, input string name);
    en        = v.en;
    dw        = v.dw;
    dw_vld    = v.vld;
    dw_last   = v.last;
    dw_nbytes = v.nb;
    pixel_rdy = v.prdy;
    #1;
    check({name, ".dw_rdy"}, {31'd0, dw_rdy}, {31'd0, v.exp_rdy});
    @(posedge clk);
    #1;
    check({name, ".pixel_data"}, {8'd0, pixel_data}, {8'd0, v.exp_data});
    check({name, ".pixel_vld"}, {31'd0, pixel_vld}, {31'd0, v.exp_vld});
    check({name, ".pixel_last"}, {31'd0, pixel_last}, {31'd0, v.exp_last});
    check({name, ".len_err"}, {31'd0, len_err}, {31'd0, v.exp_err});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t s;
    //          en  dw            vld   last  nb    prdy  rdy   data       vld   last  err
    // 3-dword line -> 4 pixels, phase-3 slot drops dw_rdy
    vec[0]  = '{1'b1, 32'h44332211, 1'b1, 1'b0, 3'd4, 1'b1, 1'b1, 24'h332211, 1'b1, 1'b0, 1'b0};
    vec[1]  = '{1'b1, 32'h88776655, 1'b1, 1'b0, 3'd4, 1'b1, 1'b1, 24'h665544, 1'b1, 1'b0, 1'b0};
    vec[2]  = '{1'b1, 32'hCCBBAA99, 1'b1, 1'b1, 3'd4, 1'b1, 1'b1, 24'h998877, 1'b1, 1'b0, 1'b0};
    vec[3]  = '{1'b1, 32'h11111111, 1'b1, 1'b0, 3'd4, 1'b1, 1'b0, 24'hCCBBAA, 1'b1, 1'b1, 1'b0};
    vec[4]  = '{1'b1, 32'h0,        1'b0, 1'b0, 3'd4, 1'b1, 1'b1, 24'hCCBBAA, 1'b0, 1'b0, 1'b0};
    // 1-pixel line, then 2-pixel line starting on the very next cycle
    vec[5]  = '{1'b1, 32'h00CCBBAA, 1'b1, 1'b1, 3'd3, 1'b1, 1'b1, 24'hCCBBAA, 1'b1, 1'b1, 1'b0};
    vec[6]  = '{1'b1, 32'h44332211, 1'b1, 1'b0, 3'd4, 1'b1, 1'b1, 24'h332211, 1'b1, 1'b0, 1'b0};
    vec[7]  = '{1'b1, 32'h00006655, 1'b1, 1'b1, 3'd2, 1'b1, 1'b1, 24'h665544, 1'b1, 1'b1, 1'b0};
    vec[8]  = '{1'b1, 32'h0,        1'b0, 1'b1, 3'd0, 1'b1, 1'b1, 24'h665544, 1'b0, 1'b0, 1'b0};
    // Bad lengths: 4 bytes, nbytes 0, 1 byte; len_err is sticky
    vec[9]  = '{1'b1, 32'h44332211, 1'b1, 1'b1, 3'd4, 1'b1, 1'b1, 24'h332211, 1'b1, 1'b1, 1'b1};
    vec[10] = '{1'b1, 32'hDEADBEEF, 1'b1, 1'b1, 3'd0, 1'b1, 1'b1, 24'h332211, 1'b0, 1'b0, 1'b1};
    vec[11] = '{1'b1, 32'h0,        1'b0, 1'b0, 3'd4, 1'b1, 1'b1, 24'h332211, 1'b0, 1'b0, 1'b1};
    vec[12] = '{1'b1, 32'h000000AB, 1'b1, 1'b1, 3'd1, 1'b1, 1'b1, 24'h332211, 1'b0, 1'b0, 1'b1};
    // Enable low clears len_err and outputs
    vec[13] = '{1'b0, 32'h0,        1'b0, 1'b0, 3'd4, 1'b1, 1'b0, 24'h000000, 1'b0, 1'b0, 1'b0};
    vec[14] = '{1'b1, 32'h0,        1'b0, 1'b0, 3'd4, 1'b1, 1'b1, 24'h000000, 1'b0, 1'b0, 1'b0};

    rst_n     = 1'b0;
    en        = 1'b1;
    dw        = '0;
    dw_vld    = 1'b0;
    dw_last   = 1'b0;
    dw_nbytes = 3'd4;
    pixel_rdy = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset.pixel_data", {8'd0, pixel_data}, 32'd0);
    check("reset.pixel_vld", {31'd0, pixel_vld}, 32'd0);
    check("reset.pixel_last", {31'd0, pixel_last}, 32'd0);
    check("reset.len_err", {31'd0, len_err}, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < NVEC; i++) step(vec[i], $sformatf("vec%0d", i));

    // Stall: pixel_rdy low for 5 cycles mid-line with a dword waiting.
    step('{1'b1, 32'h44332211, 1'b1, 1'b0, 3'd4, 1'b1, 1'b1, 24'h332211, 1'b1, 1'b0, 1'b0}, "stall_first");
    for (int i = 0; i < 5; i++)
      step('{1'b1, 32'h88776655, 1'b1, 1'b0, 3'd4, 1'b0, 1'b0, 24'h332211, 1'b1, 1'b0, 1'b0},
           $sformatf("stall_hold%0d", i));
    step('{1'b1, 32'h88776655, 1'b1, 1'b0, 3'd4, 1'b1, 1'b1, 24'h665544, 1'b1, 1'b0, 1'b0}, "stall_release");
    step('{1'b1, 32'hCCBBAA99, 1'b1, 1'b1, 3'd4, 1'b1, 1'b1, 24'h998877, 1'b1, 1'b0, 1'b0}, "stall_third");
    step('{1'b1, 32'h0,        1'b0, 1'b0, 3'd4, 1'b1, 1'b0, 24'hCCBBAA, 1'b1, 1'b1, 1'b0}, "stall_ph3");
    step('{1'b1, 32'h0,        1'b0, 1'b0, 3'd4, 1'b1, 1'b1, 24'hCCBBAA, 1'b0, 1'b0, 1'b0}, "stall_idle");

    // Enable dropped at phase 2: outputs clear and the next dword decodes as phase 0.
    step('{1'b1, 32'h44332211, 1'b1, 1'b0, 3'd4, 1'b1, 1'b1, 24'h332211, 1'b1, 1'b0, 1'b0}, "en_dw0");
    step('{1'b1, 32'h88776655, 1'b1, 1'b0, 3'd4, 1'b1, 1'b1, 24'h665544, 1'b1, 1'b0, 1'b0}, "en_dw1");
    step('{1'b0, 32'hCCBBAA99, 1'b1, 1'b0, 3'd4, 1'b1, 1'b0, 24'h000000, 1'b0, 1'b0, 1'b0}, "en_off");
    s = '{1'b1, 32'h00ABCDEF, 1'b1, 1'b1, 3'd3, 1'b1, 1'b1, 24'hABCDEF, 1'b1, 1'b1, 1'b0};
    step(s, "en_restart");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/csi2rx_rgb888_b2p.md
Name: csi2rx_rgb888_b2p

Overview:
- Receive-side RGB888 byte-to-pixel unpacker: the inverse of the transmit-side pixel-to-dword packer.
- Takes a stream of 32-bit payload dwords from the packet layer and emits 24-bit RGB888 pixels, one per clock when unstalled. Every 3 full dwords yield 4 pixels.
- Sits between the CSI-2 RX payload extractor and the pixel interface. Has valid/ready handshaking on both sides.
- Handles the partial final dword of a line and flags lengths that are not a whole number of pixels.

Parameters:
- None. Widths are fixed: dword 32 bits, pixel 24 bits.

Ports:
- clk  input  1  block clock.
- rst_n  input  1  reset, synchronous, active-low.
- rgb888_convrn_enable  input  1  unpacker enable. Low = flush and hold idle.
- dw  input  32  payload dword, little-endian byte order (byte0 = dw[7:0]).
- dw_vld  input  1  dw valid.
- dw_last  input  1  dw is the final dword of the line payload.
- dw_nbytes  input  3  number of valid bytes in the dword (1..4). Sampled only with dw_last; otherwise 4 is implied.
- dw_rdy  output  1  dword accepted this cycle when dw_vld && dw_rdy.
- pixel_data  output  24  unpacked pixel: [7:0] first byte, [23:16] third byte.
- pixel_vld  output  1  pixel_data valid.
- pixel_last  output  1  final pixel of the line; qualified by pixel_vld.
- pixel_rdy  input  1  downstream accepts the pixel.
- len_err  output  1  sticky: line byte count was not a multiple of 3, or dw_nbytes was illegal.

Behaviour:
Reset and enable
- rst_n low at a clk edge clears everything: pixel_data=0, pixel_vld=0, pixel_last=0, len_err=0, phase=0, residue=0, last_pend=0.
- rgb888_convrn_enable low has the same clearing effect. dw_rdy=0 while low. Deasserting enable mid-line discards any partial pixel.

Datapath state
- phase[1:0] = number of bytes held in the residue register res[23:0]: 0, 1, 2 or 3.

Handshake
- out_load = !pixel_vld || pixel_rdy.
- dw_rdy = enable && out_load && (phase != 3). dw_rdy is combinational from registered state and pixel_rdy; it has no path from dw_vld.
- The output register loads only when out_load. pixel_data, pixel_vld and pixel_last hold while pixel_vld && !pixel_rdy.

Accepted dword, not last (latency 1 clk, dword to pixel)
- phase 0: pixel = dw[23:0]; res[7:0] = dw[31:24]; phase -> 1.
- phase 1: pixel = {dw[15:0], res[7:0]}; res[15:0] = dw[31:16]; phase -> 2.
- phase 2: pixel = {dw[7:0], res[15:0]}; res = dw[31:8]; phase -> 3.
- Each of these sets pixel_vld=1 and pixel_last=0.

Phase 3 (no dword consumed)
- When out_load: pixel = res; pixel_vld=1; pixel_last=last_pend; phase -> 0; last_pend=0.

Idle output
- When out_load, phase != 3 and no dword is accepted: pixel_vld <= 0 and pixel_last <= 0.

Accepted dword with dw_last (t = phase + dw_nbytes)
- t==3: emit the pixel per the phase rule with pixel_last=1; phase -> 0; res cleared.
- t==6 (phase 2, nbytes 4): emit per the phase-2 rule; phase -> 3; last_pend=1. The phase-3 pixel then carries pixel_last=1.
- t==4 or t==5: emit per the phase rule with pixel_last=1; len_err <= 1; discard leftover bytes; phase -> 0.
- t<3: no pixel emitted (pixel_vld <= 0); len_err <= 1; phase -> 0.
- dw_nbytes of 0 or 5..7: dword consumed but discarded; no pixel; len_err <= 1; phase -> 0; last_pend=0.

Misc
- dw_last with dw_vld low is ignored.
- Back-to-back lines need no gap: phase 0 after a last dword accepts the next line's first dword on the next cycle.
- Throughput: 4 pixels per 3 accepted dwords. dw_rdy drops for exactly 1 cycle per phase-3 slot when unstalled.
- len_err clears only on reset or enable low.

Test Plan:
- 3 dwords 0x44332211, 0x88776655, 0xCCBBAA99 (last=1 on the third, nbytes=4), pixel_rdy=1 -> pixels 0x332211, 0x665544, 0x998877, 0xCCBBAA (last=1 on the fourth) on consecutive clocks; dw_rdy=0 on the phase-3 cycle; len_err=0.
- 1-pixel line: dw=0x00CCBBAA, last, nbytes=3 -> single pixel 0xCCBBAA with pixel_last=1; phase 0 afterwards; next line's first dword accepted the following cycle.
- 2-pixel line: dw0=0x44332211 then dw1=0x00006655 (last, nbytes=2) -> 0x332211, then 0x665544 with last=1; len_err=0.
- pixel_rdy held low for 5 cycles mid-line -> pixel_data/pixel_vld stable, dw_rdy=0, no dword lost; order preserved after release.
- Bad lengths: dw=0x44332211 (last, nbytes=4), then separately nbytes=0 -> first case emits 0x332211 with last=1 and sets len_err; nbytes=0 emits no pixel; len_err stays 1 until enable low.
- Enable deasserted at phase 2 mid-line, then reasserted -> outputs cleared to 0; next dword decoded as phase 0 (pixel = dw[23:0]).
